// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-side register file and its pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned AW      = $clog2(NREGS);
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [XLEN-1:0]  xlen_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam reg_addr_t XZERO    = '0;
  localparam cnt_t      CNT_FULL = cnt_t'(CNT_MAX);
  localparam cnt_t      CNT_ONE  = cnt_t'(1);

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback bus from the writeback stage into the register file.
interface regfile_scoreboard_if;
  import regfile_pkg::*;

  reg_addr_t wb_rd;
  xlen_t     wb_data;
  logic      wb_regwen;

  modport master (output wb_rd, output wb_data, output wb_regwen);
  modport slave  (input  wb_rd, input  wb_data, input  wb_regwen);

endinterface

// File: rtl/regfile_scoreboard_pending_counter_bank.sv
// Per-register in-flight write counters with pend/full vectors.
// REGFILE_WB_BYPASS_EN: a register whose last outstanding write lands this cycle is not pending.
module pending_counter_bank
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_fire,
  input  reg_addr_t        issue_rd,
  input  logic             wb_regwen,
  input  reg_addr_t        wb_rd,
  output logic [NREGS-1:0] pend,
  output logic [NREGS-1:0] full
);

  cnt_t             cnt_q [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;

  // x0 is excluded: its entry is never incremented, decremented or reported.
  always_comb begin
    inc  = '0;
    dec  = '0;
    pend = '0;
    full = '0;
    for (int i = 1; i < NREGS; i++) begin
      inc[i]  = issue_fire && (issue_rd == reg_addr_t'(i));
      dec[i]  = wb_regwen && (wb_rd == reg_addr_t'(i)) && (cnt_q[i] != '0);
      pend[i] = (cnt_q[i] != '0);
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_regwen && (wb_rd == reg_addr_t'(i)) && (cnt_q[i] == CNT_ONE)) begin
        pend[i] = 1'b0;
      end
`endif
      full[i] = (cnt_q[i] == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (inc[i] && !dec[i] && !full[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with two combinational read ports and a pending-write scoreboard for decode.
// REGFILE_WB_BYPASS_EN: reads of the register being written back return wb_data in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      rs1_used,
  input  logic      rs2_used,
  output xlen_t     rs1_data,
  output xlen_t     rs2_data,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      issue_regwen,
  output logic      stall,
  regfile_scoreboard_if.slave wb
);

  xlen_t            regs_q [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] full;
  logic             accept;
  logic             issue_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb.wb_regwen && (wb.wb_rd != XZERO)) begin
      regs_q[wb.wb_rd] <= wb.wb_data;
    end
  end

  // Read ports; x0 is hardwired to zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != XZERO) begin
      rs1_data = regs_q[rs1_addr];
`ifdef REGFILE_WB_BYPASS_EN
      if (wb.wb_regwen && (wb.wb_rd == rs1_addr)) rs1_data = wb.wb_data;
`endif
    end
    if (rs2_addr != XZERO) begin
      rs2_data = regs_q[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
      if (wb.wb_regwen && (wb.wb_rd == rs2_addr)) rs2_data = wb.wb_data;
`endif
    end
  end

  // Hazard check: unresolved source operand or a destination counter already at its limit.
  always_comb begin
    stall      = 1'b0;
    accept     = 1'b0;
    issue_fire = 1'b0;
    if (rst) begin
      stall = 1'b1;
    end else if (issue_valid) begin
      stall = (rs1_used && (rs1_addr != XZERO) && pend[rs1_addr]) ||
              (rs2_used && (rs2_addr != XZERO) && pend[rs2_addr]) ||
              (issue_regwen && (issue_rd != XZERO) && full[issue_rd]);
      accept     = !stall;
      issue_fire = accept && issue_regwen;
    end
  end

  pending_counter_bank u_cnt (
    .clk        (clk),
    .rst        (rst),
    .issue_fire (issue_fire),
    .issue_rd   (issue_rd),
    .wb_regwen  (wb.wb_regwen),
    .wb_rd      (wb.wb_rd),
    .pend       (pend),
    .full       (full)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t rs1_addr, rs2_addr, issue_rd;
  logic      rs1_used, rs2_used, issue_valid, issue_regwen;
  xlen_t     rs1_data, rs2_data;
  logic      stall;

  regfile_scoreboard_if wbi ();

  regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_regwen (issue_regwen),
    .stall        (stall),
    .wb           (wbi.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          cs;
    logic        s;
    bit          c1;
    logic [31:0] d1;
    bit          c2;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string nm, input bit cs, input logic s,
                     input bit c1, input logic [31:0] d1,
                     input bit c2, input logic [31:0] d2);
    exp_t e;
    e.name = nm; e.cs = cs; e.s = s; e.c1 = c1; e.d1 = d1; e.c2 = c2; e.d2 = d2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_regwen = 0; issue_rd = '0;
    rs1_used = 0; rs2_used = 0; rs1_addr = '0; rs2_addr = '0;
    wbi.wb_regwen = 0; wbi.wb_rd = '0; wbi.wb_data = '0;
  endtask

  task automatic wb(input int rd, input logic [31:0] d);
    wbi.wb_regwen = 1; wbi.wb_rd = reg_addr_t'(rd); wbi.wb_data = d;
  endtask

  task automatic issue_w(input int rd);
    issue_valid = 1; issue_regwen = 1; issue_rd = reg_addr_t'(rd);
  endtask

  task automatic rd_ops(input int a1, input logic u1, input int a2, input logic u2);
    issue_valid = 1; rs1_addr = reg_addr_t'(a1); rs1_used = u1;
    rs2_addr = reg_addr_t'(a2); rs2_used = u2;
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.cs) begin
          total++;
          if (stall !== e.s) begin
            bad++;
            $display("FAIL %s stall got=%0b want=%0b", e.name, stall, e.s);
          end
        end
        if (e.c1) begin
          total++;
          if (rs1_data !== e.d1) begin
            bad++;
            $display("FAIL %s rs1_data got=%08h want=%08h", e.name, rs1_data, e.d1);
          end
        end
        if (e.c2) begin
          total++;
          if (rs2_data !== e.d2) begin
            bad++;
            $display("FAIL %s rs2_data got=%08h want=%08h", e.name, rs2_data, e.d2);
          end
        end
      end else if (stim_done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1;
    tick();
    rd_ops(0, 0, 0, 0);
    chk("rst_stall", 1, 1, 0, 0, 0, 0);
    tick();
    rst = 0;

    for (int i = 1; i < 32; i++) begin
      idle(); rd_ops(i, 1, 32 - i, 1);
      chk("reset_read", 1, 0, 1, 32'h0, 1, 32'h0);
      tick();
    end

    idle(); wb(0, 32'hFFFF_FFFF); rd_ops(0, 1, 0, 1);
    chk("x0_wb_cycle", 1, 0, 1, 32'h0, 1, 32'h0); tick();
    idle(); rd_ops(0, 1, 0, 1);
    chk("x0_after_wb", 1, 0, 1, 32'h0, 1, 32'h0); tick();
    for (int i = 0; i < 4; i++) begin
      idle(); issue_w(0);
      chk("x0_not_counted", 1, 0, 0, 0, 0, 0); tick();
    end

    idle(); wb(5, 32'h1234_5678); tick();
    idle(); rd_ops(5, 1, 5, 0);
    chk("basic_read", 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678); tick();

    idle(); issue_w(7);
    chk("raw_issue", 1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      idle(); rd_ops(0, 0, 7, 1);
      chk("raw_stall", 1, 1, 0, 0, 1, 32'h0); tick();
    end
    idle(); rs2_addr = 5'd7; rs2_used = 1;
    chk("raw_no_valid", 1, 0, 0, 0, 0, 0); tick();
    idle(); rd_ops(0, 0, 7, 1); wb(7, 32'hA5A5_A5A5);
    chk("raw_wb_cycle", 1, !BYP, 0, 0, 1, BYP ? 32'hA5A5_A5A5 : 32'h0); tick();
    idle(); rd_ops(0, 0, 7, 1);
    chk("raw_after_wb", 1, 0, 0, 0, 1, 32'hA5A5_A5A5); tick();

    for (int i = 0; i < 3; i++) begin
      idle(); issue_w(3);
      chk("waw_issue", 1, 0, 0, 0, 0, 0); tick();
    end
    idle(); issue_w(3);
    chk("waw_full", 1, 1, 0, 0, 0, 0); tick();
    idle(); rd_ops(3, 1, 0, 0); wb(3, 32'h31);
    chk("waw_wb1", 1, 1, 1, BYP ? 32'h31 : 32'h0, 0, 0); tick();
    idle(); rd_ops(3, 1, 0, 0); wb(3, 32'h32);
    chk("waw_wb2", 1, 1, 1, BYP ? 32'h32 : 32'h31, 0, 0); tick();
    idle(); rd_ops(3, 1, 0, 0); wb(3, 32'h33);
    chk("waw_wb3", 1, !BYP, 1, BYP ? 32'h33 : 32'h32, 0, 0); tick();
    idle(); rd_ops(3, 1, 0, 0);
    chk("waw_clear", 1, 0, 1, 32'h33, 0, 0); tick();

    idle(); issue_w(9);
    chk("x9_issue", 1, 0, 0, 0, 0, 0); tick();
    idle(); issue_w(9); wb(9, 32'h99);
    chk("x9_issue_wb", 1, 0, 0, 0, 0, 0); tick();
    idle(); rd_ops(9, 1, 0, 0);
    chk("x9_still_pend", 1, 1, 1, 32'h99, 0, 0); tick();
    idle(); rd_ops(9, 1, 0, 0); wb(9, 32'h9A);
    chk("x9_wb", 1, !BYP, 1, BYP ? 32'h9A : 32'h99, 0, 0); tick();
    idle(); rd_ops(9, 1, 0, 0);
    chk("x9_clear", 1, 0, 1, 32'h9A, 0, 0); tick();

    idle(); wb(10, 32'hDEAD_BEEF); tick();
    idle(); rd_ops(10, 1, 10, 1);
    chk("x10_unsolicited", 1, 0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF); tick();

    idle(); wb(4, 32'h44); tick();
    for (int i = 0; i < 2; i++) begin
      idle(); issue_w(4);
      chk("x4_issue", 1, 0, 0, 0, 0, 0); tick();
    end
    idle(); rd_ops(4, 1, 0, 0);
    chk("x4_pend", 1, 1, 1, 32'h44, 0, 0); tick();
    rst = 1;
    idle(); rd_ops(4, 1, 0, 0);
    chk("mid_rst_stall", 1, 1, 0, 0, 0, 0); tick();
    rst = 0;
    idle(); rd_ops(4, 1, 5, 1);
    chk("post_rst", 1, 0, 1, 32'h0, 1, 32'h0); tick();

    idle();
    stim_done = 1'b1;
  end

endmodule
